// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl
//   Machine-mode CSR file and trap/mret sequencer for core_l0.
//   Serves Zicsr accesses from execute, sequences trap entry
//   (mepc/mtval, then mcause/mstatus, then redirect to mtvec) and mret
//   return (mstatus restore, then redirect to mepc).
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   csr_valid/ready   CSR request handshake
//   csr_addr/op/wdata CSR address, operation, rs1/uimm operand
//   csr_rdata         old CSR value (0 on illegal access)
//   csr_illegal       access is illegal; no state changes
//   trap_valid/cause/pc/tval  trap request from execute/mem
//   mret_valid        mret executing
//   busy              sequencer not idle; pipeline stalls
//   redirect_valid/pc one-cycle PC redirect pulse and its target
//
// Handshake: a CSR access takes effect in the cycle where
// csr_valid && csr_ready; csr_rdata/csr_illegal are meaningful only in
// that cycle and read 0 otherwise. csr_ready does not depend on csr_valid.
module csr_trap_ctrl #(
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] IMP_ID      = 32'h0000_0001,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_valid,
    output logic        csr_ready,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        trap_valid,
    input  logic [3:0]  trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_valid,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    // csr_addr_e encodings
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    // csr_ops_e encodings
    localparam logic [1:0] CSR_NOP   = 2'd0;
    localparam logic [1:0] CSR_WRITE = 2'd1;
    localparam logic [1:0] CSR_SET   = 2'd2;
    localparam logic [1:0] CSR_CLEAR = 2'd3;

    localparam logic [3:0] TRAP_NONE = 4'd0;

    typedef enum logic [2:0] {
        IDLE, TRAP_SAVE, TRAP_CAUSE, REDIRECT, MRET_RESTORE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cause_q;
    logic [31:2] pc_q;
    logic [31:0] tval_q;

    logic [31:2] mtvec_q;
    logic [31:2] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [31:0] mie_csr_q;
    logic [31:0] mcycle_q;
    logic        status_mie_q;
    logic        status_mpie_q;
    logic [31:0] target_q;

    logic        trap_req;
    logic        addr_hit;
    logic        read_only;
    logic        wants_write;
    logic        illegal;
    logic        csr_fire;
    logic        csr_we;
    logic [31:0] csr_old;
    logic [31:0] csr_new;

    // Read mux: also tells whether the address exists at all.
    always_comb begin
        addr_hit = 1'b1;
        csr_old  = 32'h0;
        case (csr_addr)
            A_MSTATUS:   csr_old = {24'h0, status_mpie_q, 3'b000, status_mie_q, 3'b000};
            A_MISA:      csr_old = MISA_VAL;
            A_MIE:       csr_old = mie_csr_q;
            A_MTVEC:     csr_old = {mtvec_q, 2'b00};
            A_MEPC:      csr_old = {mepc_q, 2'b00};
            A_MCAUSE:    csr_old = mcause_q;
            A_MTVAL:     csr_old = mtval_q;
            A_MIP:       csr_old = 32'h0;
            A_MCYCLE:    csr_old = mcycle_q;
            A_MVENDORID: csr_old = 32'h0;
            A_MARCHID:   csr_old = 32'h0;
            A_MIMPID:    csr_old = IMP_ID;
            A_MHARTID:   csr_old = HART_ID;
            default:     addr_hit = 1'b0;
        endcase
    end

    always_comb begin
        csr_new = csr_old;
        case (csr_op)
            CSR_WRITE: csr_new = csr_wdata;
            CSR_SET:   csr_new = csr_old | csr_wdata;
            CSR_CLEAR: csr_new = csr_old & ~csr_wdata;
            default:   csr_new = csr_old;
        endcase
    end

    // SET/CLEAR with a zero operand is a pure read, so it is legal even on
    // read-only registers.
    assign wants_write = (csr_op == CSR_WRITE) ||
                         (((csr_op == CSR_SET) || (csr_op == CSR_CLEAR)) && (csr_wdata != 32'h0));
    assign read_only   = (csr_addr[11:10] == 2'b11) || (csr_addr == A_MISA);
    assign illegal     = !addr_hit || (wants_write && read_only);

    // A real trap request (or mret) owns the CSR file this cycle.
    assign trap_req    = trap_valid && (trap_cause != TRAP_NONE);
    assign csr_ready   = (state_q == IDLE) && !trap_req && !mret_valid;
    assign csr_fire    = csr_valid && csr_ready;
    assign csr_we      = csr_fire && !illegal && wants_write;
    assign csr_rdata   = (csr_fire && !illegal) ? csr_old : 32'h0;
    assign csr_illegal = csr_fire && illegal;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (trap_req)        state_d = TRAP_SAVE;
                else if (mret_valid) state_d = MRET_RESTORE;
            end
            TRAP_SAVE:    state_d = TRAP_CAUSE;
            TRAP_CAUSE:   state_d = REDIRECT;
            MRET_RESTORE: state_d = REDIRECT;
            REDIRECT:     state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    assign busy           = (state_q != IDLE);
    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = redirect_valid ? target_q : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cause_q <= 4'h0;
            pc_q    <= 30'h0;
            tval_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && trap_req) begin
                cause_q <= trap_cause;
                pc_q    <= trap_pc[31:2];
                tval_q  <= trap_tval;
            end
        end
    end

    // CSR writes only happen in IDLE and the sequencer only updates CSRs
    // outside IDLE, so the two never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtvec_q       <= RESET_MTVEC[31:2];
            mepc_q        <= 30'h0;
            mcause_q      <= 32'h0;
            mtval_q       <= 32'h0;
            mie_csr_q     <= 32'h0;
            status_mie_q  <= 1'b0;
            status_mpie_q <= 1'b0;
            target_q      <= 32'h0;
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        status_mie_q  <= csr_new[3];
                        status_mpie_q <= csr_new[7];
                    end
                    A_MIE:    mie_csr_q <= csr_new;
                    A_MTVEC:  mtvec_q   <= csr_new[31:2];
                    A_MEPC:   mepc_q    <= csr_new[31:2];
                    A_MCAUSE: mcause_q  <= csr_new;
                    A_MTVAL:  mtval_q   <= csr_new;
                    default:  ;
                endcase
            end
            case (state_q)
                TRAP_SAVE: begin
                    mepc_q  <= pc_q;
                    mtval_q <= tval_q;
                end
                TRAP_CAUSE: begin
                    mcause_q      <= {28'h0, cause_q};
                    status_mpie_q <= status_mie_q;
                    status_mie_q  <= 1'b0;
                    target_q      <= {mtvec_q, 2'b00};
                end
                MRET_RESTORE: begin
                    status_mie_q  <= status_mpie_q;
                    status_mpie_q <= 1'b1;
                    target_q      <= {mepc_q, 2'b00};
                end
                default: ;
            endcase
        end
    end

    // A software write to mcycle replaces that cycle's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q <= 32'h0;
        end else if (csr_we && (csr_addr == A_MCYCLE)) begin
            mcycle_q <= csr_new;
        end else begin
            mcycle_q <= mcycle_q + 32'h1;
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl
//   Directed bench for csr_trap_ctrl: CSR access rules, trap and mret
//   sequencing with latency, arbitration, mcycle wrap and mid-sequence reset.
module tb_csr_trap_ctrl;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [3:0] TRAP_ECALL_M             = 4'd3;
    localparam logic [3:0] TRAP_ILLEGAL_INSTRUCTION = 4'd5;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        csr_valid = 1'b0;
    logic        csr_ready;
    logic [11:0] csr_addr = 12'h0;
    logic [1:0]  csr_op = 2'd0;
    logic [31:0] csr_wdata = 32'h0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid = 1'b0;
    logic [3:0]  trap_cause = 4'h0;
    logic [31:0] trap_pc = 32'h0;
    logic [31:0] trap_tval = 32'h0;
    logic        mret_valid = 1'b0;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    csr_trap_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_addr(csr_addr),
        .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_tval(trap_tval), .mret_valid(mret_valid),
        .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // reference cycle counter (valid until software writes mcycle)
    logic [31:0] mcyc_model;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcyc_model <= 32'h0;
        else        mcyc_model <= mcyc_model + 32'h1;
    end

    // scoreboard
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, got %h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s got %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] e, input logic [31:0] obs);
        exp_q.push_back(e);
        chk(tag, obs);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one CSR access in IDLE; checks ready, rdata and illegal
    task automatic csr_access(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input logic exp_ill, input string tag);
        csr_valid = 1'b1;
        csr_addr  = a;
        csr_op    = op;
        csr_wdata = wd;
        exp_q.push_back(32'd1);
        exp_q.push_back(exp_rd);
        exp_q.push_back({31'b0, exp_ill});
        @(negedge clk);
        chk({tag, "_ready"}, {31'b0, csr_ready});
        chk({tag, "_rdata"}, csr_rdata);
        chk({tag, "_ill"},   {31'b0, csr_illegal});
        step();
        csr_valid = 1'b0;
        csr_addr  = 12'h0;
        csr_op    = OP_NOP;
        csr_wdata = 32'h0;
    endtask

    task automatic csr_read(input logic [11:0] a, input logic [31:0] e, input string tag);
        csr_access(a, OP_NOP, 32'h0, e, 1'b0, tag);
    endtask

    // Watch the cycles after an accepted request: redirect latency, target,
    // busy cycle count and number of redirect pulses. Optionally holds
    // mret_valid high during the first two busy cycles (must be dropped).
    task automatic watch(input int exp_lat, input logic [31:0] exp_pc, input bit drop_mret,
                         input string tag);
        int lat = 0;
        int busy_cnt = 0;
        int pulses = 0;
        logic [31:0] rpc = 32'h0;
        exp_q.push_back(exp_lat);
        exp_q.push_back(exp_pc);
        exp_q.push_back(exp_lat);
        exp_q.push_back(32'd1);
        for (int k = 1; k <= 6; k++) begin
            mret_valid = drop_mret && (k <= 2);
            @(negedge clk);
            if (busy) busy_cnt++;
            if (redirect_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = k;
                    rpc = redirect_pc;
                end
            end
            step();
        end
        mret_valid = 1'b0;
        chk({tag, "_lat"},    lat);
        chk({tag, "_rpc"},    rpc);
        chk({tag, "_busy"},   busy_cnt);
        chk({tag, "_pulses"}, pulses);
    endtask

    task automatic do_trap(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] tv,
                           input logic [31:0] exp_pc, input bit drop_mret, input string tag);
        trap_valid = 1'b1;
        trap_cause = c;
        trap_pc    = pc;
        trap_tval  = tv;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        @(negedge clk);
        chk({tag, "_ready"}, {31'b0, csr_ready});
        chk({tag, "_illout"}, {31'b0, csr_illegal});
        step();
        trap_valid = 1'b0;
        trap_cause = 4'h0;
        csr_valid  = 1'b0;
        watch(3, exp_pc, drop_mret, tag);
    endtask

    task automatic do_mret(input logic [31:0] exp_pc, input string tag);
        mret_valid = 1'b1;
        exp_q.push_back(32'd0);
        @(negedge clk);
        chk({tag, "_ready"}, {31'b0, csr_ready});
        step();
        mret_valid = 1'b0;
        watch(2, exp_pc, 1'b0, tag);
    endtask

    initial begin
        int pulses;

        // reset state
        @(negedge clk);
        expect_now("rst_ready",  32'd1, {31'b0, csr_ready});
        expect_now("rst_busy",   32'd0, {31'b0, busy});
        expect_now("rst_redir",  32'd0, {31'b0, redirect_valid});
        expect_now("rst_rpc",    32'd0, redirect_pc);
        expect_now("rst_rdata",  32'd0, csr_rdata);
        expect_now("rst_ill",    32'd0, {31'b0, csr_illegal});
        step();
        step();
        rst_n = 1'b1;

        // mtvec direct mode, mcycle counting
        csr_access(A_MTVEC, OP_WRITE, 32'h0000_0103, 32'h0, 1'b0, "mtvec_wr");
        csr_read(A_MTVEC, 32'h0000_0100, "mtvec_rd");
        csr_read(A_MCYCLE, mcyc_model, "mcycle_rd0");
        csr_read(A_MCYCLE, mcyc_model, "mcycle_rd1");

        // trap entry with MIE set, mret while busy dropped
        csr_access(A_MSTATUS, OP_SET, 32'h8, 32'h0, 1'b0, "mie_set");
        do_trap(TRAP_ECALL_M, 32'h0000_0046, 32'h0, 32'h0000_0100, 1'b1, "ecall");
        csr_read(A_MEPC,    32'h0000_0044, "ecall_mepc");
        csr_read(A_MCAUSE,  32'h3,         "ecall_mcause");
        csr_read(A_MTVAL,   32'h0,         "ecall_mtval");
        csr_read(A_MSTATUS, 32'h80,        "ecall_mstatus");

        // mret return
        do_mret(32'h0000_0044, "mret");
        csr_read(A_MSTATUS, 32'h88, "mret_mstatus");

        // trap wins over same-cycle CSR write
        csr_access(A_MIE, OP_WRITE, 32'h8, 32'h0, 1'b0, "mie_wr");
        csr_valid = 1'b1;
        csr_addr  = A_MIE;
        csr_op    = OP_WRITE;
        csr_wdata = 32'h0000_FFFF;
        do_trap(TRAP_ILLEGAL_INSTRUCTION, 32'h0000_0200, 32'hFFFF_FFFF, 32'h0000_0100, 1'b0, "ill");
        csr_addr  = 12'h0;
        csr_op    = OP_NOP;
        csr_wdata = 32'h0;
        csr_read(A_MIE,     32'h8,         "ill_mie");
        csr_read(A_MCAUSE,  32'h5,         "ill_mcause");
        csr_read(A_MTVAL,   32'hFFFF_FFFF, "ill_mtval");
        csr_read(A_MEPC,    32'h0000_0200, "ill_mepc");
        csr_read(A_MSTATUS, 32'h80,        "ill_mstatus");

        // access legality and register rules
        csr_access(A_MHARTID, OP_WRITE, 32'h5, 32'h0, 1'b1, "hartid_wr");
        csr_access(12'h7C0,   OP_SET,   32'h1, 32'h0, 1'b1, "unlisted");
        csr_access(A_MHARTID, OP_SET,   32'h0, 32'h0, 1'b0, "hartid_rs0");
        csr_access(A_MISA,    OP_CLEAR, 32'h1, 32'h0, 1'b1, "misa_wr");
        csr_read(A_MISA,      32'h4000_0100, "misa_rd");
        csr_read(A_MIMPID,    32'h1,         "mimpid_rd");
        csr_read(A_MVENDORID, 32'h0,         "mvendorid_rd");
        csr_access(A_MIP, OP_WRITE, 32'h0000_FFFF, 32'h0, 1'b0, "mip_wr");
        csr_read(A_MIP, 32'h0, "mip_rd");
        csr_access(A_MSTATUS, OP_WRITE, 32'hFFFF_FFFF, 32'h80, 1'b0, "mstatus_wr");
        csr_read(A_MSTATUS, 32'h88, "mstatus_mask");
        csr_access(A_MSTATUS, OP_CLEAR, 32'h8, 32'h88, 1'b0, "mstatus_clr");
        csr_read(A_MSTATUS, 32'h80, "mstatus_clr_rd");
        csr_access(A_MTVEC, OP_CLEAR, 32'h0, 32'h100, 1'b0, "mtvec_rc0");

        // trap with TRAP_NONE is ignored
        trap_valid = 1'b1;
        trap_cause = 4'h0;
        csr_read(A_MTVEC, 32'h100, "trap_none");
        trap_valid = 1'b0;
        @(negedge clk);
        expect_now("trap_none_busy", 32'd0, {31'b0, busy});
        step();

        // mcycle write and wrap
        csr_access(A_MCYCLE, OP_WRITE, 32'hFFFF_FFFE, mcyc_model, 1'b0, "mcycle_wr");
        step();
        csr_read(A_MCYCLE, 32'hFFFF_FFFF, "mcycle_ff");
        csr_read(A_MCYCLE, 32'h0000_0000, "mcycle_wrap");

        // reset during TRAP_CAUSE
        trap_valid = 1'b1;
        trap_cause = TRAP_ECALL_M;
        trap_pc    = 32'h0000_0300;
        trap_tval  = 32'h55;
        step();
        trap_valid = 1'b0;
        trap_cause = 4'h0;
        step();
        expect_now("midrst_busy_pre", 32'd1, {31'b0, busy});
        rst_n = 1'b0;
        #1;
        expect_now("midrst_busy",  32'd0, {31'b0, busy});
        expect_now("midrst_redir", 32'd0, {31'b0, redirect_valid});
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (redirect_valid) pulses++;
            step();
            if (k == 0) rst_n = 1'b1;
        end
        expect_now("midrst_pulses", 32'd0, pulses);
        csr_read(A_MCAUSE,  32'h0, "midrst_mcause");
        csr_read(A_MTVAL,   32'h0, "midrst_mtval");
        csr_read(A_MEPC,    32'h0, "midrst_mepc");
        csr_read(A_MTVEC,   32'h0, "midrst_mtvec");
        csr_read(A_MSTATUS, 32'h0, "midrst_mstatus");
        csr_read(A_MIE,     32'h0, "midrst_mie");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
- Machine-mode CSR file plus trap sequencer for core_l0.
- Serves Zicsr instruction accesses from execute, using the isa_shared csr_addr_e and csr_ops_e encodings.
- Sequences trap entry (mepc/mtval/mcause/mstatus update, then PC redirect to mtvec) and mret return.
- Arbitrates CSR-file access between instruction CSR ops and the trap/mret sequencer.

Parameters:
- HART_ID, 0, value returned by mhartid.
- IMP_ID, 32'h0000_0001, value returned by mimpid.
- MISA_VAL, 32'h4000_0100, value returned by misa (RV32I).
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- csr_valid  in  1  CSR instruction request.
- csr_ready  out  1  CSR request accepted this cycle.
- csr_addr  in  12  CSR address (csr_addr_e).
- csr_op  in  2  csr_ops_e.
- csr_wdata  in  32  rs1 value or zero-extended uimm.
- csr_rdata  out  32  old CSR value, valid when csr_valid&&csr_ready.
- csr_illegal  out  1  illegal access, valid when csr_valid&&csr_ready.
- trap_valid  in  1  trap request from execute/mem.
- trap_cause  in  4  trap_cause_e.
- trap_pc  in  32  PC of faulting instruction.
- trap_tval  in  32  bad address or instruction word.
- mret_valid  in  1  mret executing.
- busy  out  1  sequencer not in IDLE; pipeline stalls.
- redirect_valid  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  32  redirect target.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE.
  - mtvec=RESET_MTVEC; mepc, mcause, mtval, mie, mcycle = 0.
  - mstatus.MIE (bit 3) = 0, mstatus.MPIE (bit 7) = 0.
  - All outputs 0 except csr_ready=1.
- FSM states: IDLE, TRAP_SAVE, TRAP_CAUSE, REDIRECT, MRET_RESTORE.
- IDLE priority for same-cycle requests: trap_valid > mret_valid > csr_valid.
  - trap_valid with cause != TRAP_NONE: latch cause/pc/tval, go TRAP_SAVE.
  - trap_valid with cause == TRAP_NONE: ignored.
  - mret_valid: go MRET_RESTORE.
  - csr_ready = 1 only in IDLE with no trap/mret request that cycle.
- TRAP_SAVE: mepc <= {pc[31:2],2'b00}; mtval <= tval. Next: TRAP_CAUSE.
- TRAP_CAUSE: mcause <= {28'b0, cause}; MPIE <= MIE; MIE <= 0. Next: REDIRECT with redirect_pc = {mtvec[31:2],2'b00}.
- MRET_RESTORE: MIE <= MPIE; MPIE <= 1. Next: REDIRECT with redirect_pc = mepc.
- REDIRECT: redirect_valid=1 for exactly this cycle. Next: IDLE.
- Latency: trap accepted at cycle N gives redirect_valid at N+3; mret accepted at N gives redirect at N+2.
- busy = 1 in every non-IDLE state. New requests are not sampled outside IDLE; trap_valid/mret_valid asserted while busy are dropped.
- CSR access (combinational read, write at clock edge):
  - rdata = current value.
  - new value: WRITE gives wdata; SET gives old|wdata; CLEAR gives old&~wdata; CSR_NOP gives no write.
  - SET/CLEAR with wdata==0 performs no write.
- Register rules:
  - mtvec and mepc: bits[1:0] read as 0 (direct mode only).
  - mstatus: only bits 3 and 7 are writable; all other bits read 0.
  - mip: reads 0; writes ignored, no trap.
  - mvendorid=0, marchid=0, mimpid=IMP_ID, mhartid=HART_ID, misa=MISA_VAL are read-only.
- Illegal access: csr_illegal=1, no state change, rdata=0. Applies to:
  - an unlisted address;
  - any write (WRITE, or SET/CLEAR with wdata!=0) to a read-only CSR (addr[11:10]==2'b11, or misa).
- mcycle: increments by 1 every cycle, wrapping 32'hFFFF_FFFF to 0.
  - A same-cycle CSR write to mcycle wins over the increment; the next cycle resumes incrementing from the written value.
  - Reading mcycle returns the pre-increment value.
- Reset asserted mid-sequence: immediate return to IDLE, no redirect pulse, CSRs take reset values.

Test Plan:
- Reset, then CSRRW mtvec=32'h0000_0103, read back -> rdata=32'h0000_0100; next read of mcycle is nonzero and increasing.
- trap_valid, cause=TRAP_ECALL_M, pc=32'h0000_0046, tval=0, MIE=1 -> busy for 3 cycles; redirect_valid at N+3 with redirect_pc=32'h0000_0100; mepc=32'h0000_0044, mcause=3, MPIE=1, MIE=0.
- mret after the previous trap -> redirect at N+2 with redirect_pc=32'h0000_0044; MIE=1, MPIE=1.
- Same cycle trap_valid(TRAP_ILLEGAL_INSTRUCTION, tval=32'hFFFF_FFFF) + csr_valid CSRRW mie -> csr_ready=0, mie unchanged, mcause=5, mtval=32'hFFFF_FFFF.
- CSRRW mhartid, and CSRRS to address 12'h7C0 -> csr_illegal=1 with no state change; CSRRS mhartid with wdata=0 -> csr_illegal=0, rdata=HART_ID.
- Write mcycle=32'hFFFF_FFFE, then read twice -> 32'hFFFF_FFFF then 32'h0000_0000 (wrap). Pulse rst_n low during TRAP_CAUSE -> no redirect_valid, mcause=0, busy=0.
